// File: rtl/r2otf_convert.sv
// r2otf_convert: radix-2 on-the-fly converter from an MSDF signed-digit stream
// to an (N+1)-bit two's-complement value using the Q/QM concatenation recurrence.
// Optional macro R2OTF_ERR_EN builds the sticky illegal-digit (2'b10) detector;
// without it err is tied low.
module r2otf_convert #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   d_in,
    input  logic         valid_in,
    input  logic         start,
    output logic         busy,
    output logic [N:0]   result,
    output logic         out_valid,
    output logic         err
);

    logic [N:0]    q;
    logic [N:0]    qm;
    logic [CW-1:0] count;
    logic [N:0]    base_q;
    logic [N:0]    base_qm;
    logic [N:0]    q_next;
    logic [N:0]    qm_next;
    logic          pos;
    logic          neg;
    logic          cont;
    logic          done;

    // Digit decode and one step of the recurrence; a start (or idle) step begins from Q=0/QM=-1.
    always_comb begin
        pos     = d_in == 2'b01;
        neg     = d_in == 2'b11;
        cont    = busy && !start;
        done    = valid_in && cont && count == CW'(N - 1);
        base_q  = cont ? q : '0;
        base_qm = cont ? qm : '1;
        q_next  = pos ? {base_q[N-1:0], 1'b1} : neg ? {base_qm[N-1:0], 1'b1} : {base_q[N-1:0], 1'b0};
        qm_next = pos ? {base_q[N-1:0], 1'b0} : neg ? {base_qm[N-1:0], 1'b0} : {base_qm[N-1:0], 1'b1};
    end

    // Q/QM, digit counter and busy: load on start, advance on each digit, clear on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= '0;
            qm    <= '1;
            count <= '0;
            busy  <= 1'b0;
        end else if (valid_in && (start || busy)) begin
            if (done) begin
                q     <= '0;
                qm    <= '1;
                count <= '0;
                busy  <= 1'b0;
            end else begin
                q     <= q_next;
                qm    <= qm_next;
                count <= start ? CW'(1) : count + CW'(1);
                busy  <= 1'b1;
            end
        end
    end

    // Result capture on the completing digit, with a one-cycle out_valid pulse after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= done;
            if (done) result <= q_next;
        end
    end

`ifdef R2OTF_ERR_EN
    // Sticky flag for any accepted illegal digit encoding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err <= 1'b0;
        else if (valid_in && d_in == 2'b10) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_r2otf_convert.sv
// tb_r2otf_convert: randomized and directed bench for r2otf_convert against a weighted-sum model.
module tb_r2otf_convert;

    localparam int N = 4;
    localparam logic [1:0] P = 2'b01, Z = 2'b00, M = 2'b11, X = 2'b10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   d_in = 2'b00;
    logic         valid_in = 1'b0;
    logic         start = 1'b0;
    logic         busy;
    logic [N:0]   result;
    logic         out_valid;
    logic         err;

    int compared = 0;
    int mismatched = 0;

    int m_cnt = 0;
    int m_acc = 0;
    int m_res = 0;
    bit m_busy = 0;
    bit m_ov = 0;
    bit m_err = 0;

    r2otf_convert #(.N(N)) dut (
        .clk(clk),
        .reset(reset),
        .d_in(d_in),
        .valid_in(valid_in),
        .start(start),
        .busy(busy),
        .result(result),
        .out_valid(out_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("busy", int'(busy), int'(m_busy));
        check("out_valid", int'(out_valid), int'(m_ov));
        check("result", int'($signed(result)), m_res);
        check("err", int'(err), int'(m_err));
    endtask

    task automatic model_reset();
        m_cnt = 0; m_acc = 0; m_res = 0; m_busy = 0; m_ov = 0; m_err = 0;
    endtask

    task automatic step(input logic v, input logic s, input logic [1:0] d);
        int dv;
        valid_in = v; start = s; d_in = d;
        @(posedge clk);
        #1;
        dv = (d == P) ? 1 : (d == M) ? -1 : 0;
        m_ov = 0;
        if (v) begin
`ifdef R2OTF_ERR_EN
            if (d == X) m_err = 1;
`endif
            if (s) begin
                m_acc = dv * (2 ** (N - 1));
                m_cnt = 1;
                m_busy = 1;
            end else if (m_busy) begin
                m_acc += dv * (2 ** (N - 1 - m_cnt));
                m_cnt++;
                if (m_cnt == N) begin
                    m_res = m_acc; m_ov = 1; m_busy = 0; m_cnt = 0;
                end
            end
        end
        valid_in = 0; start = 0;
        check_all();
    endtask

    task automatic op(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic [1:0] e);
        step(1, 1, a); step(1, 0, b); step(1, 0, c); step(1, 0, e);
    endtask

    task automatic do_reset();
        #2 reset = 1;
        #1 model_reset();
        check("rst_busy", int'(busy), 0);
        check("rst_ov", int'(out_valid), 0);
        check("rst_result", int'($signed(result)), 0);
        check("rst_err", int'(err), 0);
        @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 reset = 0;
        step(0, 0, Z);
        step(1, 0, P);
        op(P, Z, M, P);
        check("plan_7", int'($signed(result)), 7);
        step(0, 0, Z);
        op(M, Z, Z, Z);
        check("plan_m8", int'($signed(result)), -8);
        op(P, P, P, P);
        check("plan_15", int'($signed(result)), 15);
        op(M, M, M, M);
        check("plan_m15", int'($signed(result)), -15);
        step(1, 1, P); step(0, 0, Z); step(0, 0, Z); step(0, 0, Z);
        step(1, 0, M); step(1, 0, Z); step(1, 0, M);
        check("plan_3", int'($signed(result)), 3);
        step(1, 1, P); step(1, 0, P);
        op(M, Z, Z, P);
        check("plan_m7", int'($signed(result)), -7);
        step(1, 1, P); step(1, 0, P); step(1, 0, P); step(1, 1, M);
        step(1, 0, M); step(1, 0, M); step(1, 0, M);
        step(1, 1, P); step(1, 0, M);
        do_reset();
        op(Z, Z, Z, P);
        check("plan_1", int'($signed(result)), 1);
        op(Z, X, Z, Z);
        check("plan_x0", int'($signed(result)), 0);
        step(0, 0, Z);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic v, s;
            logic [1:0] d;
            v = $urandom_range(0, 3) != 0;
            s = m_busy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 2))
                0: d = P;
                1: d = Z;
                default: d = M;
            endcase
            step(v, s, d);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
